// File: rtl/tt_sweep_checker_pkg.sv
// tt_sweep_checker_pkg: shared state encoding and sweep sizing helpers
package tt_sweep_checker_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_APPLY = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Number of input vectors in an exhaustive sweep of n inputs
    function automatic int vec_count(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// tt_settle_timer: loadable down-counter that reports when the settle hold has elapsed
module tt_settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic zero
);

    localparam int W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Load restarts the hold; otherwise count down and stick at zero
    always_comb begin
        cnt_d = load ? W'(SETTLE) : (en && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker: drives every input vector to two gate implementations and compares their outputs
module tt_sweep_checker
    import tt_sweep_checker_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            res_a,
    input  logic            res_b,
    output logic [N_IN-1:0] vec_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   mismatch_cnt,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            first_fail_valid
);

    localparam int N_VEC = vec_count(N_IN);

    logic [1:0]      state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [N_IN:0]   cnt_q, cnt_d;
    logic [N_IN-1:0] ffv_q, ffv_d;
    logic            ffval_q, ffval_d;
    logic            in_apply, go, last, sample, miss, zero, load, en;

    // A start is only honoured outside a sweep and never alongside abort
    assign in_apply = (state_q == ST_APPLY);
    assign go       = !in_apply && start && !abort;
    assign last     = (vec_q == N_IN'(N_VEC - 1));
    assign sample   = in_apply && !abort && zero;
    assign miss     = (res_a != res_b);
    assign load     = go || (sample && !last);
    assign en       = in_apply && !abort && !zero;

    tt_settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .en    (en),
        .zero  (zero)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state; the unused encoding falls back to IDLE
    always_comb begin
        state_d = go ? ST_APPLY :
                  in_apply ? (abort ? ST_IDLE : (sample && last) ? ST_DONE : ST_APPLY) :
                  (state_q == ST_DONE) ? ST_DONE : ST_IDLE;
    end

    // Registered outputs: vector stepping, mismatch tally and first-failure capture
    always_comb begin
        vec_d   = go ? '0 : (in_apply && abort) ? '0 : (sample && !last) ? vec_q + N_IN'(1) : vec_q;
        cnt_d   = go ? '0 : (sample && miss) ? cnt_q + (N_IN+1)'(1) : cnt_q;
        ffv_d   = go ? '0 : (sample && miss && !ffval_q) ? vec_q : ffv_q;
        ffval_d = go ? 1'b0 : (sample && miss) ? 1'b1 : ffval_q;
        busy_d  = (state_d == ST_APPLY);
        done_d  = (state_d == ST_DONE);
        pass_d  = go ? 1'b0 : (sample && last) ? (cnt_d == '0) : pass_q;
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            cnt_q   <= '0;
            ffv_q   <= '0;
            ffval_q <= 1'b0;
        end else begin
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            cnt_q   <= cnt_d;
            ffv_q   <= ffv_d;
            ffval_q <= ffval_d;
        end
    end

    assign vec_out          = vec_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign mismatch_cnt     = cnt_q;
    assign first_fail_vec   = ffv_q;
    assign first_fail_valid = ffval_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// tb_tt_sweep_checker: directed scoreboard bench for the truth-table sweep checker
module tb_tt_sweep_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic start3 = 1'b0;
    int   mode = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    logic [1:0] vec;
    logic       busy, done, pass, ffval, res_a, res_b;
    logic [2:0] mcnt;
    logic [1:0] ffv;

    logic [2:0] vec3;
    logic       busy3, done3, pass3, ffval3, res_a3, res_b3;
    logic [3:0] mcnt3;
    logic [2:0] ffv3;

    typedef struct {
        int cnt;
        int ffv;
        int ffval;
        int pass;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    // NOR in gate form vs. De Morgan form, or deliberately broken variants
    assign res_a  = ~(vec[0] | vec[1]);
    assign res_b  = (mode == 0) ? (~vec[0] & ~vec[1]) : (mode == 1) ? 1'b0 : ~res_a;
    // 3-input XOR with a single planted fault at vector 101
    assign res_a3 = ^vec3;
    assign res_b3 = (vec3 == 3'd5) ? ~(vec3[0] ^ vec3[1] ^ vec3[2]) : (vec3[0] ^ vec3[1] ^ vec3[2]);

    tt_sweep_checker #(.N_IN(2), .SETTLE(1)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .abort            (abort),
        .res_a            (res_a),
        .res_b            (res_b),
        .vec_out          (vec),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .mismatch_cnt     (mcnt),
        .first_fail_vec   (ffv),
        .first_fail_valid (ffval)
    );

    tt_sweep_checker #(.N_IN(3), .SETTLE(0)) dut3 (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start3),
        .abort            (1'b0),
        .res_a            (res_a3),
        .res_b            (res_b3),
        .vec_out          (vec3),
        .busy             (busy3),
        .done             (done3),
        .pass             (pass3),
        .mismatch_cnt     (mcnt3),
        .first_fail_vec   (ffv3),
        .first_fail_valid (ffval3)
    );

    // Reference: sweep all four vectors through the same gate pair
    function automatic exp_t model(input int m);
        exp_t e;
        e = '{cnt: 0, ffv: 0, ffval: 0, pass: 0};
        for (int v = 0; v < 4; v++) begin
            int a, b;
            a = (v == 0) ? 1 : 0;
            b = (m == 0) ? a : (m == 1) ? 0 : 1 - a;
            if (a != b) begin
                if (e.ffval == 0) begin
                    e.ffv = v;
                    e.ffval = 1;
                end
                e.cnt++;
            end
        end
        e.pass = (e.cnt == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int m);
        mode = m;
        start = 1'b1;
        sbq.push_back(model(m));
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_cyc);
        int c;
        c = 0;
        while (!done && c < 40) begin
            tick();
            c++;
        end
        chk(tag, c, exp_cyc);
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sbq.pop_front();
            chk({tag, "_cnt"}, mcnt, e.cnt);
            chk({tag, "_ffv"}, ffv, e.ffv);
            chk({tag, "_ffval"}, ffval, e.ffval);
            chk({tag, "_pass"}, pass, e.pass);
            chk({tag, "_busy"}, busy, 0);
        end
    endtask

    initial begin
        // Reset values
        tick();
        tick();
        chk("rst_vec", vec, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_cnt", mcnt, 0);
        chk("rst_ffv", ffv, 0);
        chk("rst_ffval", ffval, 0);
        rst_n = 1'b1;
        tick();

        // Equivalent NOR: per-cycle vector sequence, done exactly 8 cycles after start
        launch(0);
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("seq_vec_%0d", c), vec, c >> 1);
            chk($sformatf("seq_busy_%0d", c), busy, 1);
            chk($sformatf("seq_done_%0d", c), done, 0);
            tick();
        end
        chk("seq_done_at8", done, 1);
        chk("seq_vec_hold", vec, 3);
        check_result("equiv");

        // res_b stuck low: only vector 00 differs
        launch(1);
        wait_done("stuck_len", 8);
        check_result("stuck");

        // res_b inverted: every vector differs, full-width count
        launch(2);
        wait_done("inv_len", 8);
        check_result("inv");

        // Asynchronous reset while vector 10 is applied
        mode = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("mid_vec", vec, 2);
        chk("mid_cnt", mcnt, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vec", vec, 0);
        chk("arst_busy", busy, 0);
        chk("arst_cnt", mcnt, 0);
        chk("arst_ffval", ffval, 0);
        chk("arst_done", done, 0);
        tick();
        rst_n = 1'b1;
        tick();
        launch(0);
        wait_done("post_rst_len", 8);
        check_result("post_rst");

        // start re-pulsed mid-sweep is ignored
        launch(0);
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("repulse_vec", vec, 2);
        chk("repulse_busy", busy, 1);
        wait_done("repulse_len", 4);
        check_result("repulse");

        // Abort at vector 01 keeps the partial tally
        mode = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("pre_abort_vec", vec, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_vec", vec, 0);
        chk("abort_cnt", mcnt, 1);
        chk("abort_ffval", ffval, 1);
        tick();
        tick();
        chk("abort_idle_busy", busy, 0);

        // start and abort together in IDLE: nothing happens
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        tick();
        chk("both_busy", busy, 0);
        chk("both_done", done, 0);
        chk("both_cnt", mcnt, 1);

        // N_IN=3, SETTLE=0: one cycle per vector, single fault at 101
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("n3_vec_%0d", c), vec3, c);
            chk($sformatf("n3_busy_%0d", c), busy3, 1);
            tick();
        end
        chk("n3_done", done3, 1);
        chk("n3_vec_end", vec3, 7);
        chk("n3_cnt", mcnt3, 1);
        chk("n3_ffv", ffv3, 5);
        chk("n3_pass", pass3, 0);
        repeat (20) tick();
        chk("n3_hold_done", done3, 1);
        chk("n3_hold_vec", vec3, 7);
        chk("n3_hold_cnt", mcnt3, 1);
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        chk("n3_restart_done", done3, 0);
        chk("n3_restart_busy", busy3, 1);
        chk("n3_restart_cnt", mcnt3, 0);
        chk("n3_restart_ffval", ffval3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tt_sweep_checker.md
Name: tt_sweep_checker

Overview:
- Sequential stimulus-and-check stage wrapped around the combinational gate exercises (e.g. a gate described by primitives vs. the same gate described by an expression).
- Upstream role: drives every input combination onto the two implementations under test, one vector at a time.
- Downstream role: consumes both implementations' outputs, compares them after a settle interval, and reports mismatch count, first failing vector and pass/fail.
- Replaces hand-written #delay sweeps with a clocked, self-checking block.

Parameters:
- N_IN, 2: number of inputs to the gate under test; sweep covers 2**N_IN vectors.
- SETTLE, 1: extra clock cycles each vector is held before sampling; 0 is legal.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- start, input, 1: begin a sweep; sampled only in IDLE or DONE.
- abort, input, 1: synchronous abort of a running sweep.
- res_a, input, 1: output of implementation A (gate form).
- res_b, input, 1: output of implementation B (expression form).
- vec_out, output, N_IN: current input vector to both implementations; bit 0 is the LSB input.
- busy, output, 1: high while sweeping.
- done, output, 1: high from sweep completion until next start or reset.
- pass, output, 1: high when done=1 and mismatch_cnt==0.
- mismatch_cnt, output, N_IN+1: number of mismatching vectors; width holds 2**N_IN without overflow.
- first_fail_vec, output, N_IN: vector of the first mismatch.
- first_fail_valid, output, 1: first_fail_vec holds a captured value.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; vec_out=0, busy=0, done=0, pass=0, mismatch_cnt=0, first_fail_vec=0, first_fail_valid=0, settle counter=0.
- States: IDLE, APPLY, DONE. All outputs are registered.
- IDLE or DONE with start=1 and abort=0 at edge k:
  - state becomes APPLY, vec_out=0, settle counter=SETTLE, busy=1, done=0, pass=0.
  - mismatch_cnt, first_fail_vec and first_fail_valid clear to 0.
- APPLY, each edge:
  - If settle counter != 0: decrement it.
  - Else, sample edge: if res_a != res_b, increment mismatch_cnt; if first_fail_valid=0, also capture first_fail_vec=vec_out and set first_fail_valid=1.
  - Same edge: if vec_out == 2**N_IN-1, go to DONE (busy=0, done=1, pass=(final count==0)); otherwise vec_out++ and reload settle counter=SETTLE.
- Timing:
  - Each vector is held SETTLE+1 cycles; it is sampled on the last edge of that hold.
  - Sweep length from the start edge to done=1 is exactly (2**N_IN)*(SETTLE+1) cycles.
- DONE: vec_out holds the last vector. Results and done hold until start or reset.
- start while in APPLY: ignored, sweep continues.
- abort=1 in APPLY: next state IDLE, busy=0, done=0, vec_out=0; mismatch_cnt, first_fail_vec and first_fail_valid keep their partial values.
- abort outside APPLY: no effect.
- start and abort both high: abort wins; in IDLE or DONE nothing happens.
- Reset mid-sweep: immediate return to reset values, with no partial result retained.
- vec_out wrap: never increments past 2**N_IN-1; the end is detected, not wrapped.
- res_a/res_b are treated as settled combinational functions of vec_out. Values outside the sample edge are don't-care.

Decomposition:
- Shared package holds:
  - state encoding localparams: ST_IDLE=2'd0, ST_APPLY=2'd1, ST_DONE=2'd2; 2'd3 is illegal and decodes to IDLE.
  - the vector-count function 2**N_IN.
- One natural sub-module: tt_settle_timer.
  - Loadable down-counter of width clog2(SETTLE+1), minimum 1.
  - Inputs: load, en. Output: zero.
  - Reused by later guide checkers.

Test Plan (N_IN=2, SETTLE=1 unless stated):
- Equivalent NOR implementations on res_a/res_b, start pulsed one cycle → vec_out sequence 00,00,01,01,10,10,11,11; done=1 exactly 8 cycles after the start edge; mismatch_cnt=0; pass=1; first_fail_valid=0.
- res_b tied 0, res_a=NOR → only vector 00 mismatches: mismatch_cnt=1, first_fail_vec=2'b00, first_fail_valid=1, pass=0.
- res_b = ~res_a → mismatch_cnt=3'd4, confirming the full-width count; first_fail_vec=00; pass=0.
- rst_n pulled low during vector 10 → all outputs return to reset values immediately, without waiting for clk. After release, start runs a clean sweep with mismatch_cnt=0.
- start re-pulsed mid-sweep: ignored, completion still at cycle 8. abort at vector 01 with res_b tied 0 → IDLE, busy=0, done=0, mismatch_cnt=1 retained. start and abort high together in IDLE → remains IDLE.
- SETTLE=0, N_IN=3 → each vector is held 1 cycle; done arrives 8 cycles after start; vec_out stops at 3'b111; result holds in DONE for 20 cycles until the next start clears it.
